pulse_gen: RTL and testbench

// Transmit side of the serial pulse protocol consumed by the pulse detector: emits a

---
 rtl/pulse_pkg.sv | 26 ++
 rtl/pulse_gap_timer.sv | 41 ++++
 rtl/pulse_gen.sv | 130 +++++++++++++
 tb/tb_pulse_gen.sv | 343 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pulse_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : pulse_pkg
//  Purpose  : Shared definitions for the serial pulse protocol transmitter.
//             It holds the generator state encoding and the minimum inter-pulse
//             gap. The pulse detector's test environment uses it as well.
//  Contents : pulse_state_t  - generator FSM states
//             PULSE_MIN_GAP  - smallest low gap after a pulse, in clk cycles
//  Revision : 1.0 - initial release
// ============================================================================
package pulse_pkg;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        LEAD = 3'd1,
        HIGH = 3'd2,
        GAP  = 3'd3,
        DONE = 3'd4
    } pulse_state_t;

    // A requested gap of 0 is stretched to this value. The stretch keeps every
    // pulse framed 0-1-0 on the line.
    localparam int PULSE_MIN_GAP = 1;

endpackage : pulse_pkg
`default_nettype wire

// File: rtl/pulse_gap_timer.sv
`default_nettype none
// ============================================================================
//  Module   : pulse_gap_timer
//  Purpose  : Down counter that times the low gap following each pulse.
//  Ports    : clk      - clock, rising edge
//             rst_n    - synchronous reset, active-low
//             load     - load load_val (takes priority over dec)
//             load_val - value to load
//             dec      - decrement by one; holds at zero, never wraps
//             zero     - counter currently at zero
//  Revision : 1.0 - initial release
// ============================================================================
module pulse_gap_timer
    import pulse_pkg::*;
#(
    parameter int GAP_W = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic [GAP_W-1:0] load_val,
    input  logic             dec,
    output logic             zero
);

    logic [GAP_W-1:0] r_count;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_count <= '0;
        end else if (load) begin
            r_count <= load_val;
        end else if (dec && (r_count != '0)) begin
            r_count <= r_count - GAP_W'(1);
        end
    end

    assign zero = (r_count == '0);

endmodule : pulse_gap_timer
`default_nettype wire

// File: rtl/pulse_gen.sv
`default_nettype none
// ============================================================================
//  Module   : pulse_gen
//  Purpose  : Transmit side of the serial pulse protocol. For each accepted
//             request it emits req_count single-cycle pulses on data_out.
//             Each pulse is framed 0-1-0, so a downstream detector sees one
//             event per pulse.
//  Ports    : clk, rst_n         - clock / synchronous active-low reset
//             req_valid/ready    - request handshake (ready only when idle)
//             req_count, req_gap - pulses to send / low cycles after each
//             abort              - cancel the request in progress
//             data_out           - registered serial pulse line
//             busy, done,        - status: not idle / normal completion
//             aborted            - strobe / abort strobe
//             remaining          - pulses still to send (0 when idle)
//  Revision : 1.0 - initial release
// ============================================================================
module pulse_gen
    import pulse_pkg::*;
#(
    parameter int CNT_W = 8,
    parameter int GAP_W = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [CNT_W-1:0] req_count,
    input  logic [GAP_W-1:0] req_gap,
    input  logic             abort,
    output logic             data_out,
    output logic             busy,
    output logic             done,
    output logic             aborted,
    output logic [CNT_W-1:0] remaining
);

    pulse_state_t     r_state;
    pulse_state_t     w_state_nxt;
    logic [CNT_W-1:0] r_remaining;
    logic [GAP_W-1:0] r_gap;
    logic             r_data_out;
    logic             r_aborted;
    logic             w_accept;
    logic             w_cancel;
    logic             w_gap_zero;

    assign w_accept = req_valid && (r_state == IDLE);
    // Abort takes effect only while pulses are in flight. In DONE the
    // completion stands, and in IDLE the abort is ignored.
    assign w_cancel = abort && ((r_state == LEAD) || (r_state == HIGH) ||
                                (r_state == GAP));

    // ------------------------------------------------------------------
    // Gap timer: loaded with gap-1 during HIGH, so GAP lasts exactly gap cycles.
    // r_gap is at least 1 once a request is accepted, so the subtraction
    // cannot underflow.
    // ------------------------------------------------------------------
    pulse_gap_timer #(
        .GAP_W    (GAP_W)
    ) u_gap_timer (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (r_state == HIGH),
        .load_val (r_gap - GAP_W'(1)),
        .dec      (r_state == GAP),
        .zero     (w_gap_zero)
    );

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE: begin
                if (req_valid) begin
                    w_state_nxt = (req_count != '0) ? LEAD : DONE;
                end
            end
            LEAD: w_state_nxt = abort ? IDLE : HIGH;
            HIGH: w_state_nxt = abort ? IDLE : GAP;
            GAP: begin
                if (abort) begin
                    w_state_nxt = IDLE;
                end else if (w_gap_zero) begin
                    // remaining has already been decremented on HIGH exit
                    w_state_nxt = (r_remaining != '0) ? HIGH : DONE;
                end
            end
            DONE:    w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // State, counters and registered outputs
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state     <= IDLE;
            r_remaining <= '0;
            r_gap       <= '0;
            r_data_out  <= 1'b0;
            r_aborted   <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            // The line is high exactly in the cycle the FSM spends in HIGH.
            r_data_out <= (w_state_nxt == HIGH);
            r_aborted  <= w_cancel;
            if (w_accept) begin
                r_remaining <= req_count;
                r_gap       <= (req_gap == '0) ? GAP_W'(PULSE_MIN_GAP) : req_gap;
            end else if (w_cancel) begin
                r_remaining <= '0;
            end else if ((r_state == HIGH) && (r_remaining != '0)) begin
                r_remaining <= r_remaining - CNT_W'(1);
            end
        end
    end

    assign req_ready = (r_state == IDLE);
    assign busy      = (r_state != IDLE);
    assign done      = (r_state == DONE);
    assign data_out  = r_data_out;
    assign aborted   = r_aborted;
    assign remaining = r_remaining;

endmodule : pulse_gen
`default_nettype wire

// File: tb/tb_pulse_gen.sv
`default_nettype none
// ============================================================================
//  Module   : tb_pulse_gen
//  Purpose  : Self-checking bench for pulse_gen. Expected per-cycle outputs
//             come from a waveform model built from the protocol rules.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_pulse_gen;

    localparam int CNT_W = 8;
    localparam int GAP_W = 4;

    logic             clk;
    logic             rst_n;
    logic             req_valid;
    logic             req_ready;
    logic [CNT_W-1:0] req_count;
    logic [GAP_W-1:0] req_gap;
    logic             abort;
    logic             data_out;
    logic             busy;
    logic             done;
    logic             aborted;
    logic [CNT_W-1:0] remaining;

    int errors = 0;
    int checks = 0;

    // Per-cycle vector: {data_out, done, aborted, busy, req_ready, remaining[7:0]}
    logic [12:0] exp_q[$];
    logic [12:0] obs_q[$];

    // Line monitor acting as the downstream detector
    int det_cnt = 0;
    int min_low = 1000;
    int low_run = 1000;
    bit prev_d  = 1'b0;

    pulse_gen #(
        .CNT_W     (CNT_W),
        .GAP_W     (GAP_W)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_count (req_count),
        .req_gap   (req_gap),
        .abort     (abort),
        .data_out  (data_out),
        .busy      (busy),
        .done      (done),
        .aborted   (aborted),
        .remaining (remaining)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (data_out === 1'b1) begin
            checks++;
            if (prev_d) begin
                errors++;
                $display("FAIL line_double_high: data_out=1 two cycles running, required 0 after a pulse");
            end else begin
                det_cnt++;
                if (low_run < min_low) min_low = low_run;
            end
            low_run = 0;
        end else begin
            low_run++;
        end
        prev_d = (data_out === 1'b1);
    end

    // ---------------------------------------------------------------- model
    function automatic logic [12:0] mk(input bit d, input bit dn, input bit ab,
                                       input bit bz, input int rem);
        return {d, dn, ab, bz, ~bz, rem[7:0]};
    endfunction

    // Appends the waveform of one request, starting with the cycle after the
    // accept edge and ending with the first idle cycle. abort_at is the index
    // of the cycle during which abort is held (-1 for none).
    function automatic void build_expect(input int count, input int gap, input int abort_at);
        logic [12:0] seq[$];
        int g;
        g = (gap == 0) ? 1 : gap;
        if (count == 0) begin
            seq.push_back(mk(0, 1, 0, 1, 0));
        end else begin
            seq.push_back(mk(0, 0, 0, 1, count));
            for (int k = count; k >= 1; k--) begin
                seq.push_back(mk(1, 0, 0, 1, k));
                for (int j = 0; j < g; j++) seq.push_back(mk(0, 0, 0, 1, k - 1));
            end
            seq.push_back(mk(0, 1, 0, 1, 0));
        end
        if (abort_at >= 0 && abort_at < seq.size() && seq[abort_at][11] == 1'b0) begin
            while (seq.size() > abort_at + 1) void'(seq.pop_back());
            seq.push_back(mk(0, 0, 1, 0, 0));
        end else begin
            seq.push_back(mk(0, 0, 0, 0, 0));
        end
        foreach (seq[i]) exp_q.push_back(seq[i]);
    endfunction

    // ------------------------------------------------------------- stimulus
    task automatic send_req(input int c, input int g);
        req_count = c[CNT_W-1:0];
        req_gap   = g[GAP_W-1:0];
        req_valid = 1'b1;
        @(posedge clk);
        #1;
    endtask

    // Steps through exp_q.size() cycles and records the outputs. Control inputs
    // are applied during the indexed cycle.
    task automatic play(input int abort_at, input int rst_at, input int drop_at);
        obs_q.delete();
        for (int i = 0; i < exp_q.size(); i++) begin
            if (i > 0) begin
                @(posedge clk);
                #1;
            end
            obs_q.push_back({data_out, done, aborted, busy, req_ready, remaining});
            abort = (i == abort_at);
            rst_n = (i != rst_at);
            if (i >= drop_at) req_valid = 1'b0;
        end
        abort = 1'b0;
        rst_n = 1'b1;
    endtask

    // ---------------------------------------------------------------- tests
    task automatic test_reset();
        rst_n = 1'b0; req_valid = 1'b0; abort = 1'b0; req_count = '0; req_gap = '0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        checks++;
        if ({data_out, done, aborted, busy, req_ready, remaining} !== mk(0, 0, 0, 0, 0)) begin
            errors++;
            $display("FAIL reset: got %b required %b",
                     {data_out, done, aborted, busy, req_ready, remaining}, mk(0, 0, 0, 0, 0));
        end
    endtask

    task automatic test_count3_gap2();
        int first_hi;
        int first_dn;
        exp_q.delete(); build_expect(3, 2, -1);
        send_req(3, 2); play(-1, -1, 0);
        foreach (exp_q[i]) begin
            checks++;
            if (obs_q[i] !== exp_q[i]) begin
                errors++;
                $display("FAIL count3_gap2 cyc%0d: got %b required %b", i, obs_q[i], exp_q[i]);
            end
        end
        first_hi = -1; first_dn = -1;
        foreach (obs_q[i]) begin
            if (obs_q[i][12] === 1'b1 && first_hi < 0) first_hi = i;
            if (obs_q[i][11] === 1'b1 && first_dn < 0) first_dn = i;
        end
        checks++;
        if (first_hi != 1) begin
            errors++;
            $display("FAIL first_pulse_latency: got index %0d required 1", first_hi);
        end
        checks++;
        if (first_dn != (2 + 3 * (1 + 2)) - 1) begin
            errors++;
            $display("FAIL done_latency: got index %0d required %0d", first_dn, (2 + 3 * 3) - 1);
        end
    endtask

    task automatic test_count0();
        exp_q.delete(); build_expect(0, 5, -1);
        det_cnt = 0;
        send_req(0, 5); play(-1, -1, 0);
        foreach (exp_q[i]) begin
            checks++;
            if (obs_q[i] !== exp_q[i]) begin
                errors++;
                $display("FAIL count0 cyc%0d: got %b required %b", i, obs_q[i], exp_q[i]);
            end
        end
        checks++;
        if (det_cnt != 0) begin
            errors++;
            $display("FAIL count0_pulses: got %0d required 0", det_cnt);
        end
    endtask

    task automatic test_gap0();
        exp_q.delete(); build_expect(2, 0, -1);
        det_cnt = 0;
        send_req(2, 0); play(-1, -1, 0);
        foreach (exp_q[i]) begin
            checks++;
            if (obs_q[i] !== exp_q[i]) begin
                errors++;
                $display("FAIL gap0 cyc%0d: got %b required %b", i, obs_q[i], exp_q[i]);
            end
        end
        checks++;
        if (det_cnt != 2) begin
            errors++;
            $display("FAIL gap0_detections: got %0d required 2", det_cnt);
        end
    endtask

    task automatic test_abort();
        int g;
        int a;
        g = $urandom_range(1, 3);
        a = 2 + g;                      // index of the second HIGH cycle
        exp_q.delete(); build_expect(4, g, a);
        send_req(4, g); play(a, -1, 0);
        foreach (exp_q[i]) begin
            checks++;
            if (obs_q[i] !== exp_q[i]) begin
                errors++;
                $display("FAIL abort_2nd_high cyc%0d: got %b required %b", i, obs_q[i], exp_q[i]);
            end
        end
    endtask

    task automatic test_abort_in_idle();
        exp_q.delete(); build_expect(2, 1, -1);
        abort = 1'b1;
        send_req(2, 1); play(-1, -1, 0);
        foreach (exp_q[i]) begin
            checks++;
            if (obs_q[i] !== exp_q[i]) begin
                errors++;
                $display("FAIL abort_in_idle cyc%0d: got %b required %b", i, obs_q[i], exp_q[i]);
            end
        end
    endtask

    task automatic test_reset_mid_gap();
        exp_q.delete(); build_expect(5, 2, -1);
        while (exp_q.size() > 4) void'(exp_q.pop_back());
        exp_q.push_back(mk(0, 0, 0, 0, 0));
        send_req(5, 2); play(-1, 3, 0);
        foreach (exp_q[i]) begin
            checks++;
            if (obs_q[i] !== exp_q[i]) begin
                errors++;
                $display("FAIL reset_mid_gap cyc%0d: got %b required %b", i, obs_q[i], exp_q[i]);
            end
        end
    endtask

    task automatic test_back_to_back();
        exp_q.delete(); build_expect(1, 1, -1); build_expect(1, 1, -1);
        det_cnt = 0; min_low = 1000;
        send_req(1, 1); play(-1, -1, 5);
        foreach (exp_q[i]) begin
            checks++;
            if (obs_q[i] !== exp_q[i]) begin
                errors++;
                $display("FAIL back_to_back cyc%0d: got %b required %b", i, obs_q[i], exp_q[i]);
            end
        end
        checks++;
        if (det_cnt != 2) begin
            errors++;
            $display("FAIL b2b_detections: got %0d required 2", det_cnt);
        end
        checks++;
        if (min_low < 2) begin
            errors++;
            $display("FAIL b2b_separation: got %0d low cycles required >=2", min_low);
        end
    endtask

    task automatic test_max();
        exp_q.delete(); build_expect(255, 15, -1);
        det_cnt = 0;
        send_req(255, 15); play(-1, -1, 0);
        foreach (exp_q[i]) begin
            checks++;
            if (obs_q[i] !== exp_q[i]) begin
                errors++;
                $display("FAIL max_req cyc%0d: got %b required %b", i, obs_q[i], exp_q[i]);
            end
        end
        checks++;
        if (det_cnt != 255) begin
            errors++;
            $display("FAIL max_detections: got %0d required 255", det_cnt);
        end
    endtask

    task automatic test_random();
        int c;
        int g;
        int a;
        for (int n = 0; n < 12; n++) begin
            c = $urandom_range(0, 6);
            g = $urandom_range(0, 4);
            exp_q.delete(); build_expect(c, g, -1);
            a = ($urandom_range(0, 2) == 0) ? $urandom_range(0, exp_q.size() - 2) : -1;
            exp_q.delete(); build_expect(c, g, a);
            send_req(c, g); play(a, -1, 0);
            foreach (exp_q[i]) begin
                checks++;
                if (obs_q[i] !== exp_q[i]) begin
                    errors++;
                    $display("FAIL random n%0d c%0d g%0d a%0d cyc%0d: got %b required %b",
                             n, c, g, a, i, obs_q[i], exp_q[i]);
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_count3_gap2();
        test_count0();
        test_gap0();
        test_abort();
        test_abort_in_idle();
        test_reset_mid_gap();
        test_back_to_back();
        test_max();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached before completion");
        $fatal(1, "watchdog");
    end

endmodule : tb_pulse_gen
`default_nettype wire
